// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback commit tracer.
package wb_trace_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int SEQW_DEF   = 16;
    localparam int RD_W       = 5;
    localparam int DROP_CNT_W = 16;

    // Default-width trace record: one committed register write.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [RD_W-1:0]     rd;
        logic [XLEN_DEF-1:0] data;
        logic [SEQW_DEF-1:0] seq;
    } trace_rec_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace records. The head entry is visible
// on dout_o whenever the FIFO is not empty; dout_o reads as zero when empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type rec_t = trace_rec_t
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  rec_t                   din_i,
    output rec_t                   dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    rec_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Record storage; no reset needed since contents are masked while empty.
    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit_tracer.sv
// Writeback commit tracer: captures committed register writes, tags them with
// a sequence number and streams them out through a FWFT FIFO.
// Build option: define TRACE_X0_WRITES_EN to also trace writes to x0.
module wb_commit_tracer
    import wb_trace_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 8,
    parameter int SEQW  = SEQW_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   w_enable,
    input  logic [XLEN-1:0]        w_pc,
    input  logic [RD_W-1:0]        w_destination,
    input  logic [XLEN-1:0]        w_data,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [XLEN-1:0]        trace_pc,
    output logic [RD_W-1:0]        trace_rd,
    output logic [XLEN-1:0]        trace_data,
    output logic [SEQW-1:0]        trace_seq,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_count,
    output logic [$clog2(DEPTH):0] level
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
        logic [SEQW-1:0] seq;
    } rec_t;

    logic                  capture;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    rec_t                  rec_in;
    rec_t                  rec_out;
    logic [SEQW-1:0]       seq_q, seq_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef TRACE_X0_WRITES_EN
    assign capture = w_enable;
`else
    assign capture = w_enable && (w_destination != '0);
`endif

    assign pop  = trace_valid && trace_ready;
    // A capture is lost only when the FIFO is full and nothing leaves this cycle.
    assign drop = capture && fifo_full && !pop;

    assign rec_in = '{pc: w_pc, rd: w_destination, data: w_data, seq: seq_q};

    // Next-state for sequence number and drop bookkeeping.
    always_comb begin
        seq_d      = capture ? seq_q + 1'b1 : seq_q;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    // State registers; drop status is sticky until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clock_i  (clock),
        .reset_ni (reset),
        .push_i   (capture),
        .pop_i    (trace_ready),
        .din_i    (rec_in),
        .dout_o   (rec_out),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (level)
    );

    assign trace_valid = !fifo_empty;
    assign trace_pc    = rec_out.pc;
    assign trace_rd    = rec_out.rd;
    assign trace_data  = rec_out.data;
    assign trace_seq   = rec_out.seq;
    assign overflow    = overflow_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_wb_commit_tracer.sv
// Self-checking bench for wb_commit_tracer (default parameters).
module tb_wb_commit_tracer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int SEQW  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              w_enable = 1'b0;
    logic [XLEN-1:0]   w_pc = '0;
    logic [4:0]        w_destination = '0;
    logic [XLEN-1:0]   w_data = '0;
    logic              trace_valid;
    logic              trace_ready = 1'b0;
    logic [XLEN-1:0]   trace_pc;
    logic [4:0]        trace_rd;
    logic [XLEN-1:0]   trace_data;
    logic [SEQW-1:0]   trace_seq;
    logic              overflow;
    logic [15:0]       drop_count;
    logic [3:0]        level;

    wb_commit_tracer #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQW(SEQW)) dut (
        .clock         (clock),
        .reset         (reset),
        .w_enable      (w_enable),
        .w_pc          (w_pc),
        .w_destination (w_destination),
        .w_data        (w_data),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_pc      (trace_pc),
        .trace_rd      (trace_rd),
        .trace_data    (trace_data),
        .trace_seq     (trace_seq),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .level         (level)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of records plus counters, updated per clock edge.
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] seq;
    } mrec_t;

    mrec_t m_q[$];
    int    m_seq   = 0;
    int    m_drops = 0;
    bit    m_ovf   = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic model_clear();
        m_q.delete();
        m_seq   = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic cycle(input bit en, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] data, input bit rdy);
        bit    pop;
        bit    cap;
        mrec_t r;
        w_enable      = en;
        w_destination = rd;
        w_pc          = pc;
        w_data        = data;
        trace_ready   = rdy;
        @(posedge clock);
        pop = (m_q.size() > 0) && rdy;
`ifdef TRACE_X0_WRITES_EN
        cap = en;
`else
        cap = en && (rd != 5'd0);
`endif
        if (pop) begin
            r = m_q.pop_front();
            $display("[TB] t=%0t pop  seq=%0d rd=%0d pc=%h data=%h", $time, r.seq, r.rd, r.pc, r.data);
        end
        if (cap) begin
            if (m_q.size() < DEPTH) begin
                r.pc = pc; r.rd = rd; r.data = data; r.seq = m_seq[15:0];
                m_q.push_back(r);
                $display("[TB] t=%0t push seq=%0d rd=%0d pc=%h data=%h", $time, r.seq, rd, pc, data);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
                $display("[TB] t=%0t drop seq=%0d", $time, m_seq);
            end
            m_seq = (m_seq + 1) % 65536;
        end
        #1;
    endtask

    task automatic apply_reset();
        w_enable    = 1'b0;
        trace_ready = 1'b0;
        reset       = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        tests_run++;
        if ({trace_valid, trace_pc, trace_rd, trace_data, trace_seq, overflow, drop_count, level} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b pc=%h rd=%0d data=%h seq=%0d ovf=%b drops=%0d level=%0d, want all zero",
                     trace_valid, trace_pc, trace_rd, trace_data, trace_seq, overflow, drop_count, level);
        end
        apply_reset();
    endtask

    task automatic test_single_write();
        apply_reset();
        cycle(1'b1, 5'd5, 32'h100, 32'hDEAD_BEEF, 1'b1);
        tests_run++;
        if ({trace_valid, trace_pc, trace_rd, trace_data, trace_seq} !== {1'b1, 32'h100, 5'd5, 32'hDEAD_BEEF, 16'd0}) begin
            tests_failed++;
            $display("FAIL single_head: got valid=%b pc=%h rd=%0d data=%h seq=%0d, want 1 00000100 5 deadbeef 0",
                     trace_valid, trace_pc, trace_rd, trace_data, trace_seq);
        end
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        tests_run++;
        if (trace_valid !== 1'b0 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL single_drain: got valid=%b level=%0d, want 0 0", trace_valid, level);
        end
    endtask

    task automatic test_x0_filter();
        logic [3:0] exp_level;
        logic [4:0] exp_rd;
        apply_reset();
        cycle(1'b1, 5'd0, 32'h300, 32'hAAAA_0000, 1'b0);
        cycle(1'b1, 5'd3, 32'h304, 32'hBBBB_0003, 1'b0);
`ifdef TRACE_X0_WRITES_EN
        exp_level = 4'd2;
        exp_rd    = 5'd0;
`else
        exp_level = 4'd1;
        exp_rd    = 5'd3;
`endif
        tests_run++;
        if (level !== exp_level || trace_rd !== exp_rd || trace_seq !== 16'd0 || trace_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL x0_filter: got level=%0d rd=%0d seq=%0d valid=%b, want level=%0d rd=%0d seq=0 valid=1",
                     level, trace_rd, trace_seq, trace_valid, exp_level, exp_rd);
        end
`ifdef TRACE_X0_WRITES_EN
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        tests_run++;
        if (trace_seq !== 16'd1 || trace_rd !== 5'd3) begin
            tests_failed++;
            $display("FAIL x0_second: got seq=%0d rd=%0d, want seq=1 rd=3", trace_seq, trace_rd);
        end
`endif
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'(i + 1), 32'h1000 + 32'(i * 4), $urandom, 1'b0);
        end
        tests_run++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL overflow_state: got level=%0d ovf=%b drops=%0d, want 8 1 2", level, overflow, drop_count);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (trace_valid !== 1'b1 || trace_seq !== 16'(i)) begin
                tests_failed++;
                $display("FAIL overflow_drain%0d: got valid=%b seq=%0d, want 1 %0d", i, trace_valid, trace_seq, i);
            end
            cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        end
        cycle(1'b1, 5'd4, 32'h2000, 32'h1234_5678, 1'b0);
        tests_run++;
        if (trace_seq !== 16'd10 || level !== 4'd1 || drop_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL overflow_next_seq: got seq=%0d level=%0d drops=%0d, want 10 1 2", trace_seq, level, drop_count);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 5'd9, 32'(i), $urandom, 1'b0);
        end
        cycle(1'b1, 5'd9, 32'h8, 32'h0, 1'b1);
        tests_run++;
        if (level !== 4'd8 || drop_count !== 16'd0 || overflow !== 1'b0 || trace_seq !== 16'd1) begin
            tests_failed++;
            $display("FAIL full_push_pop: got level=%0d drops=%0d ovf=%b seq=%0d, want 8 0 0 1",
                     level, drop_count, overflow, trace_seq);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        cycle(1'b1, 5'd7, 32'h200, 32'h1111_1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 5'(i + 10), $urandom, $urandom, 1'b0);
            tests_run++;
            if ({trace_valid, trace_pc, trace_rd, trace_data, trace_seq} !== {1'b1, 32'h200, 5'd7, 32'h1111_1111, 16'd0}) begin
                tests_failed++;
                $display("FAIL stall_%0d: got valid=%b pc=%h rd=%0d data=%h seq=%0d, want 1 00000200 7 11111111 0",
                         i, trace_valid, trace_pc, trace_rd, trace_data, trace_seq);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'd2, $urandom, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        tests_run++;
        if (level !== 4'd4 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_pre: got level=%0d ovf=%b, want 4 1", level, overflow);
        end
        trace_ready = 1'b0;
        reset = 1'b0;
        #2;
        tests_run++;
        if (trace_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || drop_count !== 16'd0 || trace_seq !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got valid=%b level=%0d ovf=%b drops=%0d seq=%0d, want all 0",
                     trace_valid, level, overflow, drop_count, trace_seq);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();
        cycle(1'b1, 5'd6, 32'h400, 32'h5555_5555, 1'b0);
        tests_run++;
        if (trace_valid !== 1'b1 || trace_seq !== 16'd0 || trace_pc !== 32'h400) begin
            tests_failed++;
            $display("FAIL mid_reset_seq: got valid=%b seq=%0d pc=%h, want 1 0 00000400", trace_valid, trace_seq, trace_pc);
        end
    endtask

    task automatic test_random();
        logic [84:0] obs_head;
        logic [84:0] exp_head;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom, $urandom,
                  (i % 100 < 50) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0));
            obs_head = {trace_valid, trace_pc, trace_rd, trace_data, trace_seq};
            if (m_q.size() > 0) exp_head = {1'b1, m_q[0].pc, m_q[0].rd, m_q[0].data, m_q[0].seq};
            else                exp_head = '0;
            tests_run++;
            if (obs_head !== exp_head || level !== 4'(m_q.size()) || overflow !== m_ovf || drop_count !== 16'(m_drops)) begin
                tests_failed++;
                $display("FAIL random_%0d: got head=%h level=%0d ovf=%b drops=%0d, want head=%h level=%0d ovf=%b drops=%0d",
                         i, obs_head, level, overflow, drop_count, exp_head, m_q.size(), m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_x0_filter();
        test_overflow();
        test_full_push_pop();
        test_stall();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_commit_tracer.md
Name: wb_commit_tracer

Overview:
Consumer at the far end of the core's writeback port (W_PC / W_ENABLE / W_DESTINATION / W_DATA).
- Captures each committed register write as a trace record and tags it with a sequence number.
- Buffers records in a small FIFO.
- Drains them to a debug/bench reader over a valid/ready stream.
- Sits beside the core inside design_wrapper. The testbench or a debug UART consumes its output.

Parameters:
XLEN, 32, data/PC width
DEPTH, 8, FIFO entries (power of two, >=2)
SEQW, 16, sequence-number width

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
w_enable  input  1  writeback register-write strobe
w_pc  input  XLEN  PC of the writeback instruction
w_destination  input  5  destination register index
w_data  input  XLEN  writeback data
trace_valid  output  1  record available
trace_ready  input  1  reader accepts record
trace_pc  output  XLEN  record PC
trace_rd  output  5  record destination
trace_data  output  XLEN  record data
trace_seq  output  SEQW  record sequence number
overflow  output  1  sticky: at least one record dropped
drop_count  output  16  number of dropped records, saturating
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, async assert, sync release): FIFO empty, trace_valid=0, trace_pc/rd/data/seq=0, overflow=0, drop_count=0, level=0, internal seq counter=0.
- Capture condition: w_enable=1 AND w_destination!=0 (x0 writes filtered; see optional feature).
- On a capture cycle the record {w_pc, w_destination, w_data, seq} is pushed. seq increments by 1 mod 2^SEQW on every capture, including dropped ones, so gaps in trace_seq reveal drops.
- Latency: a record captured at edge N appears on trace_* with trace_valid=1 after edge N, i.e. one cycle later, when the FIFO was empty.
- Output is a FWFT FIFO head. trace_* is stable while trace_valid=1 and trace_ready=0.
- Pop on trace_valid & trace_ready at the rising edge.
- Full (level==DEPTH):
  - capture with no pop in the same cycle -> record dropped, overflow<=1, drop_count+1 (saturates at 16'hFFFF).
  - capture with a pop in the same cycle -> push accepted, level unchanged.
- Empty: capture and trace_ready in the same cycle -> no pop (trace_valid=0). Push lands and is visible next cycle.
- Pointers wrap mod DEPTH. level = push count minus pop count, range 0..DEPTH.
- overflow and drop_count clear only on reset.
- Reset asserted mid-stream: all buffered records are discarded immediately. No partial record is ever presented.

Optional Feature:
Macro TRACE_X0_WRITES_EN.
- Defined: capture condition is w_enable=1 only. x0 writes are traced and consume seq numbers.
- Undefined: x0 writes are ignored entirely and do not advance seq.

Decomposition:
- Package wb_trace_pkg holds:
  - typedef struct packed trace_rec_t {pc, rd, data, seq}
  - localparams for default XLEN/SEQW
  - DROP_CNT_W=16
- One sub-module: trace_fifo.
  - Parameterised sync FWFT FIFO of trace_rec_t with push, pop, full, empty, level.
  - Tracer top contains only capture/seq/overflow logic.

Test Plan:
- Single write: reset, then w_enable=1, rd=5, pc=0x100, data=0xDEAD_BEEF with trace_ready=1 -> next cycle trace_valid=1, pc=0x100, rd=5, data=0xDEADBEEF, seq=0; following cycle trace_valid=0.
- x0 filter: w_enable=1, rd=0 followed by rd=3 -> only the rd=3 record, seq=0. With TRACE_X0_WRITES_EN: two records, seq 0 and 1.
- Backpressure/overflow: trace_ready=0, 10 consecutive captures with DEPTH=8 -> level=8, overflow=1, drop_count=2. Then trace_ready=1 drains seq 0..7 in order, and the next capture carries seq=10.
- Full with simultaneous push/pop: fill to 8, then one capture with trace_ready=1 -> level stays 8, drop_count unchanged, head advances to seq=1.
- Stall stability: trace_valid=1, trace_ready=0 for 5 cycles while new captures arrive -> trace_* unchanged throughout.
- Mid-stream reset: 4 records buffered, pulse reset low for 1 cycle -> trace_valid=0, level=0, overflow=0. The next capture gets seq=0.
